// File: rtl/exec_muldiv_unit.sv
// Iterative RV32M multiply/divide execution unit behind the order/accepted dispatch handshake.
// One operation at a time, fixed LEN_WORD-cycle latency, result held on a valid/ready writeback port.
module exec_muldiv_unit #(
  parameter int LEN_WORD      = 32,
  parameter int LEN_PREG_ADDR = 6,
  parameter int LEN_CONTEXT   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     order,
  input  logic [2:0]               order_func3,
  input  logic [LEN_WORD-1:0]      order_d_rs1,
  input  logic [LEN_WORD-1:0]      order_d_rs2,
  input  logic [LEN_PREG_ADDR-1:0] order_pa_rd,
  input  logic [LEN_CONTEXT-1:0]   order_context,
  output logic                     accepted,
  input  logic                     branch_hazard,
  input  logic [LEN_CONTEXT-1:0]   hazard_context_info,
  output logic                     busy,
  output logic                     wb_valid,
  output logic [LEN_PREG_ADDR-1:0] wb_pa_rd,
  output logic [LEN_WORD-1:0]      wb_data,
  input  logic                     wb_ready
);
  localparam int CW = $clog2(LEN_WORD);
  localparam logic [CW-1:0] LAST = CW'(LEN_WORD - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            cnt;
  logic [2:0]               func3_q;
  logic [LEN_CONTEXT-1:0]   ctx_q;
  logic [2*LEN_WORD-1:0]    acc;
  logic [LEN_WORD-1:0]      opb;
  logic                     neg_q;

  logic                     kill, take;
  logic [LEN_CONTEXT-1:0]   ctx_sel;

  // operand conditioning at dispatch
  logic                     is_div, sgn_a, sgn_b, neg_in;
  logic [LEN_WORD-1:0]      mag_a, mag_b;

  always_comb begin
    is_div = order_func3[2];
    sgn_a  = (order_func3 == 3'b001 || order_func3 == 3'b010 ||
              order_func3 == 3'b100 || order_func3 == 3'b110) && order_d_rs1[LEN_WORD-1];
    sgn_b  = (order_func3 == 3'b001 || order_func3 == 3'b100 ||
              order_func3 == 3'b110) && order_d_rs2[LEN_WORD-1];
    mag_a  = sgn_a ? -order_d_rs1 : order_d_rs1;
    mag_b  = sgn_b ? -order_d_rs2 : order_d_rs2;
    if (!is_div)
      neg_in = sgn_a ^ sgn_b;
    else if (order_func3[1])
      neg_in = sgn_a;
    else
      // quotient of a divide by zero is all ones regardless of dividend sign
      neg_in = (sgn_a ^ sgn_b) && (order_d_rs2 != '0);
  end

  // one iteration of shift-add / restoring shift-subtract
  logic [LEN_WORD:0]        msum, trial;
  logic [2*LEN_WORD-1:0]    acc_step;

  always_comb begin
    msum  = {1'b0, acc[2*LEN_WORD-1:LEN_WORD]} + (acc[0] ? {1'b0, opb} : {(LEN_WORD+1){1'b0}});
    trial = acc[2*LEN_WORD-1:LEN_WORD-1] - {1'b0, opb};
    if (!func3_q[2])
      acc_step = {msum, acc[LEN_WORD-1:1]};
    else if (trial[LEN_WORD])
      acc_step = {acc[2*LEN_WORD-2:0], 1'b0};
    else
      acc_step = {trial[LEN_WORD-1:0], acc[LEN_WORD-2:0], 1'b1};
  end

  // sign fix-up and result selection from the final iteration
  logic [2*LEN_WORD-1:0]    prod_s;
  logic [LEN_WORD-1:0]      quot_s, rem_s, result;

  always_comb begin
    prod_s = neg_q ? -acc_step : acc_step;
    quot_s = neg_q ? -acc_step[LEN_WORD-1:0] : acc_step[LEN_WORD-1:0];
    rem_s  = neg_q ? -acc_step[2*LEN_WORD-1:LEN_WORD] : acc_step[2*LEN_WORD-1:LEN_WORD];
    case (func3_q)
      3'b000:                 result = acc_step[LEN_WORD-1:0];
      3'b001, 3'b010, 3'b011: result = prod_s[2*LEN_WORD-1:LEN_WORD];
      3'b100, 3'b101:         result = quot_s;
      default:                result = rem_s;
    endcase
  end

  always_comb begin
    ctx_sel  = (state == IDLE) ? order_context : ctx_q;
    kill     = branch_hazard && |(hazard_context_info & ctx_sel);
    accepted = order && (state == IDLE) && !rst;
    take     = accepted && !kill;
    busy     = (state != IDLE);
    wb_valid = (state == DONE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (take) state_nxt = BUSY;
      BUSY: begin
        if (kill)             state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = DONE;
      end
      DONE: if (kill || wb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      func3_q  <= '0;
      ctx_q    <= '0;
      acc      <= '0;
      opb      <= '0;
      neg_q    <= 1'b0;
      wb_pa_rd <= '0;
      wb_data  <= '0;
    end else if (state == IDLE) begin
      if (take) begin
        cnt      <= '0;
        func3_q  <= order_func3;
        ctx_q    <= order_context;
        acc      <= {{LEN_WORD{1'b0}}, mag_a};
        opb      <= mag_b;
        neg_q    <= neg_in;
        wb_pa_rd <= order_pa_rd;
      end
    end else if (state == BUSY && !kill) begin
      acc <= acc_step;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) wb_data <= result;
    end
  end

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Self-checking bench for exec_muldiv_unit: vector table for arithmetic results,
// hand sequences for reset, backpressure and context squashing.
module tb_exec_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        order;
  logic [2:0]  order_func3;
  logic [31:0] order_d_rs1, order_d_rs2;
  logic [5:0]  order_pa_rd;
  logic [1:0]  order_context;
  logic        accepted;
  logic        branch_hazard;
  logic [1:0]  hazard_context_info;
  logic        busy, wb_valid;
  logic [5:0]  wb_pa_rd;
  logic [31:0] wb_data;
  logic        wb_ready;

  exec_muldiv_unit dut (
    .clk(clk), .rst(rst), .order(order), .order_func3(order_func3),
    .order_d_rs1(order_d_rs1), .order_d_rs2(order_d_rs2), .order_pa_rd(order_pa_rd),
    .order_context(order_context), .accepted(accepted), .branch_hazard(branch_hazard),
    .hazard_context_info(hazard_context_info), .busy(busy), .wb_valid(wb_valid),
    .wb_pa_rd(wb_pa_rd), .wb_data(wb_data), .wb_ready(wb_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  pa;
  } sb_t;

  vec_t vecs[16];
  sb_t  sbq[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // drive one offer at #1 after an edge, check acceptance, consume the edge
  task automatic offer(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] pa, input logic [1:0] ctx, input logic [31:0] exp);
    sb_t e;
    order = 1'b1; order_func3 = f; order_d_rs1 = a; order_d_rs2 = b;
    order_pa_rd = pa; order_context = ctx;
    #1;
    chk("accepted", {31'b0, accepted}, 32'd1);
    e.data = exp; e.pa = pa;
    sbq.push_back(e);
    @(posedge clk); #1;
    order = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (wb_valid) begin lat = n; break; end
    end
    chk({name, "_latency"}, lat, 32'd32);
  endtask

  task automatic check_result(input string name);
    sb_t e;
    if (sbq.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk({name, "_data"}, wb_data, e.data);
      chk({name, "_pa"}, {26'b0, wb_pa_rd}, {26'b0, e.pa});
    end
  endtask

  task automatic run_to_wb(input string name);
    int lat;
    wait_valid(name, lat);
    if (lat != 0) begin
      check_result(name);
      @(posedge clk); #1;
      chk({name, "_idle_after"}, {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    int   lat;
    logic seen;

    vecs[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{3'b001, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2]  = '{3'b011, 32'h00000007, 32'hFFFFFFFD, 32'h00000006};
    vecs[3]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
    vecs[6]  = '{3'b101, 32'h80000000, 32'h00000000, 32'hFFFFFFFF};
    vecs[7]  = '{3'b111, 32'h80000000, 32'h00000000, 32'h80000000};
    vecs[8]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[9]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[10] = '{3'b101, 32'd100,      32'd7,        32'd14};
    vecs[11] = '{3'b111, 32'd100,      32'd7,        32'd2};
    vecs[12] = '{3'b100, 32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD};
    vecs[13] = '{3'b110, 32'd20,       32'hFFFFFFFA, 32'd2};
    vecs[14] = '{3'b100, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF};
    vecs[15] = '{3'b110, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB};

    rst = 1'b1; order = 1'b1; order_func3 = '0; order_d_rs1 = '0; order_d_rs2 = '0;
    order_pa_rd = '0; order_context = 2'b01; branch_hazard = 1'b0;
    hazard_context_info = '0; wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_accepted", {31'b0, accepted}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_pa", {26'b0, wb_pa_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    order = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // reset in the middle of a multiply
    offer(3'b000, 32'd3, 32'd4, 6'd9, 2'b01, 32'd12);
    repeat (10) @(posedge clk);
    #1; rst = 1'b1; #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("midrst_wb_data", wb_data, 32'd0);
    sbq.delete();
    @(posedge clk); #1; rst = 1'b0;
    offer(3'b000, 32'd3, 32'd4, 6'd9, 2'b01, 32'd12);
    run_to_wb("after_rst");

    for (int i = 0; i < 16; i++) begin
      offer(vecs[i].f, vecs[i].a, vecs[i].b, 6'(i + 5), 2'b01, vecs[i].exp);
      run_to_wb($sformatf("vec%0d", i));
    end

    // writeback backpressure
    wb_ready = 1'b0;
    offer(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd33, 2'b10, 32'hFFFFFFFE);
    wait_valid("bp", lat);
    if (lat != 0) begin
      check_result("bp");
      for (int k = 0; k < 5; k++) begin
        order = 1'b1; order_func3 = 3'b000; order_pa_rd = 6'd1;
        @(posedge clk); #1;
        chk("bp_accepted", {31'b0, accepted}, 32'd0);
        chk("bp_valid", {31'b0, wb_valid}, 32'd1);
        chk("bp_data", wb_data, 32'hFFFFFFFE);
        chk("bp_pa", {26'b0, wb_pa_rd}, 32'd33);
      end
      wb_ready = 1'b1; #1;
      chk("hs_accepted", {31'b0, accepted}, 32'd0);
      @(posedge clk); #1;
      order = 1'b0;
      chk("hs_idle", {31'b0, busy}, 32'd0);
    end
    offer(3'b000, 32'd6, 32'd7, 6'd2, 2'b10, 32'd42);
    run_to_wb("after_bp");

    // squash in BUSY, matching context
    offer(3'b000, 32'd5, 32'd5, 6'd3, 2'b01, 32'd25);
    repeat (12) @(posedge clk);
    #1; branch_hazard = 1'b1; hazard_context_info = 2'b01;
    @(posedge clk); #1; branch_hazard = 1'b0; hazard_context_info = 2'b00;
    chk("squash_busy", {31'b0, busy}, 32'd0);
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (wb_valid) seen = 1'b1;
    end
    chk("squash_no_wb", {31'b0, seen}, 32'd0);
    void'(sbq.pop_front());

    // hazard on a different context leaves the operation alone
    offer(3'b100, 32'd100, 32'd9, 6'd4, 2'b01, 32'd11);
    repeat (11) @(posedge clk);
    #1; branch_hazard = 1'b1; hazard_context_info = 2'b10;
    @(posedge clk); #1; branch_hazard = 1'b0; hazard_context_info = 2'b00;
    chk("nosquash_busy", {31'b0, busy}, 32'd1);
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (wb_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("nosquash_valid", {31'b0, seen}, 32'd1);
    if (seen) begin
      check_result("nosquash");
      @(posedge clk); #1;
    end

    // kill in the same cycle as dispatch
    order = 1'b1; order_func3 = 3'b000; order_d_rs1 = 32'd2; order_d_rs2 = 32'd2;
    order_pa_rd = 6'd7; order_context = 2'b10;
    branch_hazard = 1'b1; hazard_context_info = 2'b10;
    #1;
    chk("dispkill_accepted", {31'b0, accepted}, 32'd1);
    @(posedge clk); #1;
    order = 1'b0; branch_hazard = 1'b0; hazard_context_info = 2'b00;
    chk("dispkill_busy", {31'b0, busy}, 32'd0);
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (wb_valid || busy) seen = 1'b1;
    end
    chk("dispkill_no_wb", {31'b0, seen}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
